// File: rtl/dbus_wb_master.sv
// Bridges a simple valid/ready core data port onto a Wishbone classic master, one transfer at a time.
// Optional bus-hang watchdog: define DBUS_WB_MASTER_TIMEOUT_EN to abort after TIMEOUT_CYCLES.
module dbus_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        dvalid,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  input  logic        dwrite,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        derr,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] drdata_q, drdata_d;
  logic        derr_q, derr_d;

`ifdef DBUS_WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] tmo_q, tmo_d;
`else
  logic [7:0] unused_tmo_cfg;
  assign unused_tmo_cfg = 8'(TIMEOUT_CYCLES);
`endif

  // Next-state and datapath capture
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    drdata_d = drdata_q;
    derr_d   = derr_q;
`ifdef DBUS_WB_MASTER_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (dvalid) begin
          state_d = S_BUS;
          adr_d   = {daddr[31:2], 2'b00};
          dat_d   = dwdata;
          sel_d   = dwrite ? dwstb : 4'hF;
          we_d    = dwrite;
`ifdef DBUS_WB_MASTER_TIMEOUT_EN
          tmo_d   = 8'd0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUS: begin
        // Error wins over a simultaneous ack
        if (wb_err_i) begin
          state_d  = S_RESP;
          derr_d   = 1'b1;
          drdata_d = 32'h0000_0000;
        end else if (wb_ack_i) begin
          state_d = S_RESP;
          derr_d  = 1'b0;
          if (!we_q) begin
            drdata_d = wb_dat_i;
          end else begin
            drdata_d = drdata_q;
          end
        end else begin
`ifdef DBUS_WB_MASTER_TIMEOUT_EN
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TMO_LIMIT) begin
            state_d  = S_RESP;
            derr_d   = 1'b1;
            drdata_d = 32'hDEAD_BEEF;
          end else begin
            state_d = S_BUS;
          end
`else
          state_d = S_BUS;
`endif
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        derr_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and capture registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= S_IDLE;
      adr_q    <= 32'h0000_0000;
      dat_q    <= 32'h0000_0000;
      sel_q    <= 4'h0;
      we_q     <= 1'b0;
      drdata_q <= 32'h0000_0000;
      derr_q   <= 1'b0;
`ifdef DBUS_WB_MASTER_TIMEOUT_EN
      tmo_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      drdata_q <= drdata_d;
      derr_q   <= derr_d;
`ifdef DBUS_WB_MASTER_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  // Bus strobes are pure decodes of the state register, so they drop with an async reset
  assign wb_cyc_o = (state_q == S_BUS);
  assign wb_stb_o = (state_q == S_BUS);
  assign wb_we_o  = (state_q == S_BUS) & we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = dat_q;
  assign drdata   = drdata_q;
  assign dready   = (state_q == S_RESP);
  assign derr     = derr_q;

endmodule
